// File: rtl/button_event_counter.sv
// button_event_counter: synchronise, debounce and count two push-buttons (up/down) into an LED value.
// Optional AUTOREPEAT_EN macro adds hold-to-repeat press events per button.
module button_event_counter #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       buttons,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       held,
    output logic [1:0]       press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          held_q, held_d;
    logic [1:0]          press_q, press_d;
    logic [1:0][CW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [1:0]          mis, acc;

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);
    logic [1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]         rep_phase_q, rep_phase_d, rep_hit, rep_run;
`endif

    always_comb begin
        mis = sync2_q ^ held_q;
        for (int i = 0; i < 2; i++) begin
            acc[i] = mis[i] && (deb_cnt_q[i] == DEB_MAX);
            deb_cnt_d[i] = (!mis[i] || acc[i]) ? '0 : deb_cnt_q[i] + 1'b1;
        end
        // an accepted change always flips the debounced level
        held_d = held_q ^ acc;
        press_d = acc & sync2_q;
`ifdef AUTOREPEAT_EN
        for (int i = 0; i < 2; i++) begin
            rep_run[i] = held_q[i] && held_d[i];
            rep_hit[i] = rep_run[i] && (rep_cnt_q[i] == (rep_phase_q[i] ? PER_MAX : DLY_MAX));
            rep_cnt_d[i] = (!rep_run[i] || rep_hit[i]) ? '0 : rep_cnt_q[i] + 1'b1;
            rep_phase_d[i] = rep_run[i] && (rep_phase_q[i] || rep_hit[i]);
        end
        press_d = press_d | rep_hit;
`endif
        count_d = (press_q == 2'b01) ? count_q + 1'b1 :
                  (press_q == 2'b10) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            held_q      <= '0;
            press_q     <= '0;
            deb_cnt_q   <= '0;
            count_q     <= '0;
`ifdef AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_phase_q <= '0;
`endif
        end else begin
            sync1_q     <= buttons;
            sync2_q     <= sync1_q;
            held_q      <= held_d;
            press_q     <= press_d;
            deb_cnt_q   <= deb_cnt_d;
            count_q     <= count_d;
`ifdef AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
`endif
        end
    end

    assign led   = count_q;
    assign held  = held_q;
    assign press = press_q;
endmodule

// File: tb/tb_button_event_counter.sv
// tb_button_event_counter: directed checks of sync, debounce, press events, wrap and repeat.
module tb_button_event_counter;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] buttons = 2'b00;
    logic [3:0] led;
    logic [1:0] held;
    logic [1:0] press;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int p0_n = 0;
    int p1_n = 0;
    int p11_n = 0;
    int p0_edges[$];

    button_event_counter #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .buttons(buttons),
        .led(led),
        .held(held),
        .press(press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_n++;
        if (press[0]) begin
            p0_n++;
            p0_edges.push_back(cyc_n);
        end
        if (press[1]) p1_n++;
        if (press == 2'b11) p11_n++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        buttons = 2'b00;
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (led !== 4'd0) begin errors++; $display("FAIL reset_led: got %0d expected 0", led); end
        checks++; if (held !== 2'b00) begin errors++; $display("FAIL reset_held: got %b expected 00", held); end
        checks++; if (press !== 2'b00) begin errors++; $display("FAIL reset_press: got %b expected 00", press); end
        buttons = 2'b01;
        tick(7);
        checks++; if (led !== 4'd1) begin errors++; $display("FAIL pre_reset_led: got %0d expected 1", led); end
        #3;
        resetn = 1'b0;
        #1;
        checks++; if (led !== 4'd0) begin errors++; $display("FAIL async_reset_led: got %0d expected 0", led); end
        checks++; if (held !== 2'b00) begin errors++; $display("FAIL async_reset_held: got %b expected 00", held); end
        checks++; if (press !== 2'b00) begin errors++; $display("FAIL async_reset_press: got %b expected 00", press); end
        tick(1);
        resetn = 1'b1;
        tick(5);
        checks++; if (held !== 2'b00) begin errors++; $display("FAIL requalify_early: got %b expected 00", held); end
        tick(1);
        checks++; if (held !== 2'b01 || press !== 2'b01) begin errors++; $display("FAIL requalify_accept: got held=%b press=%b expected 01/01", held, press); end
        tick(1);
        checks++; if (led !== 4'd1) begin errors++; $display("FAIL requalify_led: got %0d expected 1", led); end
        buttons = 2'b00;
        tick(8);
        do_reset();
    endtask

    task automatic test_clean_press;
        int s;
        s = p0_n;
        buttons = 2'b01;
        tick(5);
        checks++; if (press !== 2'b00) begin errors++; $display("FAIL clean_early_press: got %b expected 00", press); end
        tick(1);
        checks++; if (press !== 2'b01 || held !== 2'b01 || led !== 4'd0) begin errors++; $display("FAIL clean_accept: got press=%b held=%b led=%0d expected 01/01/0", press, held, led); end
        tick(1);
        checks++; if (press !== 2'b00 || led !== 4'd1) begin errors++; $display("FAIL clean_after: got press=%b led=%0d expected 00/1", press, led); end
        tick(3);
        buttons = 2'b00;
        tick(10);
        checks++; if (held !== 2'b00 || led !== 4'd1) begin errors++; $display("FAIL clean_release: got held=%b led=%0d expected 00/1", held, led); end
        checks++; if (p0_n - s !== 1) begin errors++; $display("FAIL clean_pulse_count: got %0d expected 1", p0_n - s); end
    endtask

    task automatic test_bounce;
        int s;
        s = p0_n;
        for (int i = 0; i < 5; i++) begin
            buttons = 2'b01;
            tick(2);
            buttons = 2'b00;
            tick(2);
        end
        tick(8);
        checks++; if (p0_n !== s || held !== 2'b00 || led !== 4'd1) begin errors++; $display("FAIL bounce: got pulses=%0d held=%b led=%0d expected 0/00/1", p0_n - s, held, led); end
        buttons = 2'b01;
        tick(3);
        buttons = 2'b00;
        tick(10);
        checks++; if (p0_n !== s || led !== 4'd1) begin errors++; $display("FAIL short_pulse: got pulses=%0d led=%0d expected 0/1", p0_n - s, led); end
    endtask

    task automatic test_wrap;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            buttons = 2'b01;
            tick(8);
            buttons = 2'b00;
            tick(8);
            if (i == 14) begin
                checks++; if (led !== 4'd15) begin errors++; $display("FAIL wrap_15: got %0d expected 15", led); end
            end
        end
        checks++; if (led !== 4'd0) begin errors++; $display("FAIL wrap_up: got %0d expected 0", led); end
        buttons = 2'b10;
        tick(8);
        buttons = 2'b00;
        tick(8);
        checks++; if (led !== 4'd15) begin errors++; $display("FAIL wrap_down: got %0d expected 15", led); end
    endtask

    task automatic test_simultaneous;
        int s;
        s = p11_n;
        buttons = 2'b11;
        tick(6);
        checks++; if (press !== 2'b11 || held !== 2'b11) begin errors++; $display("FAIL simul_accept: got press=%b held=%b expected 11/11", press, held); end
        tick(1);
        checks++; if (led !== 4'd15 || press !== 2'b00) begin errors++; $display("FAIL simul_led: got led=%0d press=%b expected 15/00", led, press); end
        tick(3);
        buttons = 2'b00;
        tick(10);
        checks++; if (held !== 2'b00 || led !== 4'd15 || p11_n - s !== 1) begin errors++; $display("FAIL simul_release: got held=%b led=%0d pulses=%0d expected 00/15/1", held, led, p11_n - s); end
    endtask

    task automatic test_autorepeat;
        int s;
        do_reset();
        p0_edges.delete();
        s = p0_n;
        buttons = 2'b01;
        tick(50);
        buttons = 2'b00;
        tick(20);
`ifdef AUTOREPEAT_EN
        checks++; if (p0_n - s !== 5 || led !== 4'd5) begin errors++; $display("FAIL repeat_count: got pulses=%0d led=%0d expected 5/5", p0_n - s, led); end
        if (p0_edges.size() >= 5) begin
            for (int i = 1; i < 5; i++) begin
                checks++; if (p0_edges[i] - p0_edges[i-1] !== (i == 1 ? 20 : 8)) begin errors++; $display("FAIL repeat_gap%0d: got %0d expected %0d", i, p0_edges[i] - p0_edges[i-1], (i == 1 ? 20 : 8)); end
            end
        end
`else
        checks++; if (p0_n - s !== 1 || led !== 4'd1) begin errors++; $display("FAIL no_repeat: got pulses=%0d led=%0d expected 1/1", p0_n - s, led); end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_simultaneous();
        test_autorepeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
